// File: rtl/data_register_pkg.sv
// Shared datapath definitions: word width and word type used by the
// accumulator, the general-purpose registers and the holding registers.
package data_register_pkg;

    localparam int DATA_WIDTH = 16;

    typedef logic [DATA_WIDTH-1:0] data_t;

endpackage : data_register_pkg

// File: rtl/data_register.sv
// Parallel-load storage register. It clears asynchronously on an active-low
// reset, captures `in` on a rising clock edge when `load` is high, and holds otherwise.
module data_register
    import data_register_pkg::*;
#(
    parameter int               WIDTH       = DATA_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    // `out` comes straight from the flops, so reset is its only combinational path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= RESET_VALUE;
        end else if (load) begin
            out <= in;
        end
    end

endmodule : data_register

// File: tb/tb_data_register.sv
// Directed bench for data_register. A word-level model is checked against the
// DUT on every falling edge, and literal expectations are checked at key points.
module tb_data_register;

    localparam int          W       = 16;
    localparam logic [W-1:0] RST_VAL = 16'h0000;

    logic         clk;
    logic         reset;
    logic         load;
    logic [W-1:0] in_word;
    logic [W-1:0] out_word;

    int compared   = 0;
    int mismatched = 0;
    bit running    = 1'b1;

    logic [W-1:0] exp_word = RST_VAL;

    data_register #(.WIDTH(W), .RESET_VALUE(RST_VAL)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .in    (in_word),
        .out   (out_word)
    );

    // Clock and reset: 20 ns period, rising edges at 10, 30, 50 ns.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Reference model: the register contents described as a stored word.
    function automatic logic [W-1:0] next_word(input logic [W-1:0] cur, input logic rst,
                                               input logic ld, input logic [W-1:0] d);
        if (!rst)    return RST_VAL;
        else if (ld) return d;
        else         return cur;
    endfunction

    always @(posedge clk) exp_word = next_word(exp_word, reset, load, in_word);
    always @(negedge reset) exp_word = RST_VAL;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: out=%h expected=%h at %0t", name, act, req, $time);
        end
    endtask

    // Compare process: the output must match the model at every falling edge.
    always @(negedge clk) begin
        if (running) check("model", out_word, exp_word);
    end

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         ld;
        logic [W-1:0] d;
        logic [W-1:0] want;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 16'h1234, 16'h1234};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h1234};
        vecs[2] = '{1'b1, 16'h0001, 16'h0001};
        vecs[3] = '{1'b0, 16'h8000, 16'h0001};
        vecs[4] = '{1'b1, 16'h8000, 16'h8000};
        vecs[5] = '{1'b1, 16'hA5C3, 16'hA5C3};

        // Power-on with reset held low.
        reset   = 1'b0;
        load    = 1'b0;
        in_word = 16'h0000;
        #1;
        check("por_t0", out_word, 16'h0000);
        repeat (3) after_edge();
        check("por_edges", out_word, 16'h0000);

        // Release reset between edges, then present a load.
        #5 reset = 1'b1;
        after_edge();
        load    = 1'b1;
        in_word = 16'hAA11;
        #3;
        check("load_not_before", out_word, 16'h0000);
        after_edge();
        check("load_aa11", out_word, 16'hAA11);

        // Hold for three edges with `in` changed.
        load    = 1'b0;
        in_word = 16'h0000;
        repeat (3) after_edge();
        check("hold_aa11", out_word, 16'hAA11);

        // Asynchronous clear mid-cycle with a load pending.
        load    = 1'b1;
        in_word = 16'hAA11;
        #5 reset = 1'b0;
        #1;
        check("async_clear", out_word, 16'h0000);
        repeat (2) after_edge();
        check("clear_held", out_word, 16'h0000);

        // Recovery: first load at the first edge after release.
        #2;
        reset   = 1'b1;
        load    = 1'b1;
        in_word = 16'h5555;
        after_edge();
        check("recover_5555", out_word, 16'h5555);
        load    = 1'b0;
        in_word = 16'h0000;
        repeat (2) after_edge();
        check("hold_5555", out_word, 16'h5555);

        // Width and bit-order patterns on consecutive edges.
        load    = 1'b1;
        in_word = 16'hFFFF;
        after_edge();
        check("pat_ffff", out_word, 16'hFFFF);
        in_word = 16'h8001;
        after_edge();
        check("pat_8001", out_word, 16'h8001);
        in_word = 16'h0000;
        after_edge();
        check("pat_0000", out_word, 16'h0000);

        // Directed table of loads and holds.
        foreach (vecs[i]) begin
            load    = vecs[i].ld;
            in_word = vecs[i].d;
            after_edge();
            check($sformatf("vec%0d", i), out_word, vecs[i].want);
        end
        load = 1'b0;
        repeat (2) after_edge();
        check("vec_hold", out_word, 16'hA5C3);

        @(posedge clk);
        running = 1'b0;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_data_register
